// File: rtl/pixel_array_if.sv
// Bus bundle between the pixel array controller and the camera top level:
// frame request, pixel strobes, shared DATA bus halves and the pixel stream.
interface pixel_array_if;
    logic       start;
    logic       ERASE;
    logic       EXPOSE;
    logic       CONVERT;
    logic [3:0] READ;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in;
    logic [7:0] pix_data;
    logic [1:0] pix_index;
    logic       pix_valid;
    logic       busy;
    logic       frame_done;

    // Controller side.
    modport master (
        input  start, data_in,
        output ERASE, EXPOSE, CONVERT, READ, data_out, data_oe,
        output pix_data, pix_index, pix_valid, busy, frame_done
    );

    // Camera top level / array side.
    modport slave (
        output start, data_in,
        input  ERASE, EXPOSE, CONVERT, READ, data_out, data_oe,
        input  pix_data, pix_index, pix_valid, busy, frame_done
    );
endinterface

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the 2x2 pixel array: erase, expose, ramp conversion with
// a shared ADC count on DATA, bus turnaround, then per-pixel readback.
// All outputs are registered from the next-state decode, so every strobe is
// glitch-free and changes exactly on the state boundary.
module pixel_array_ctrl #(
    parameter int C_ERASE    = 5,
    parameter int C_EXPOSE   = 255,
    parameter int C_READ     = 2,
    parameter int USE_GRAY   = 1,
    parameter int CONTINUOUS = 0
) (
    input  logic          clk,
    input  logic          reset,
    pixel_array_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_TURN    = 3'd4,
        ST_READ    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [8:0] ERASE_LAST  = 9'(C_ERASE - 1);
    localparam logic [8:0] EXPOSE_LAST = 9'(C_EXPOSE - 1);
    localparam logic [8:0] CONV_LAST   = 9'd255;
    localparam logic [8:0] READ_LAST   = 9'(C_READ - 1);

    function automatic logic [7:0] bin2gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [7:0] gray2bin(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    state_t     state_r, state_nx_s;
    logic [8:0] phase_r, phase_nx_s;
    logic [1:0] idx_r, idx_nx_s;

    logic       erase_r, expose_r, convert_r, oe_r, busy_r, done_r, valid_r;
    logic [3:0] read_r;
    logic [7:0] dout_r, pix_r;
    logic [1:0] pix_idx_r;

    logic       erase_s, expose_s, convert_s, oe_s, busy_s, done_s, valid_s;
    logic [3:0] read_s;
    logic [7:0] dout_s, pix_s, code_s;
    logic [1:0] pix_idx_s;
    logic       cap_s;

    // State, phase counter and pixel index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            phase_r <= 9'd0;
            idx_r   <= 2'd0;
        end else begin
            state_r <= state_nx_s;
            phase_r <= phase_nx_s;
            idx_r   <= idx_nx_s;
        end
    end

    // Next-state, phase and pixel index; phase restarts at 0 on every state change.
    always_comb begin
        state_nx_s = state_r;
        phase_nx_s = phase_r + 9'd1;
        idx_nx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                phase_nx_s = 9'd0;
                idx_nx_s   = 2'd0;
                if (bus.start) begin
                    state_nx_s = ST_ERASE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ERASE: begin
                if (phase_r == ERASE_LAST) begin
                    state_nx_s = ST_EXPOSE;
                    phase_nx_s = 9'd0;
                end else begin
                    state_nx_s = ST_ERASE;
                end
            end
            ST_EXPOSE: begin
                if (phase_r == EXPOSE_LAST) begin
                    state_nx_s = ST_CONVERT;
                    phase_nx_s = 9'd0;
                end else begin
                    state_nx_s = ST_EXPOSE;
                end
            end
            ST_CONVERT: begin
                if (phase_r == CONV_LAST) begin
                    state_nx_s = ST_TURN;
                    phase_nx_s = 9'd0;
                end else begin
                    state_nx_s = ST_CONVERT;
                end
            end
            ST_TURN: begin
                state_nx_s = ST_READ;
                phase_nx_s = 9'd0;
                idx_nx_s   = 2'd0;
            end
            ST_READ: begin
                if (phase_r == READ_LAST) begin
                    phase_nx_s = 9'd0;
                    if (idx_r == 2'd3) begin
                        state_nx_s = ST_DONE;
                        idx_nx_s   = 2'd0;
                    end else begin
                        state_nx_s = ST_READ;
                        idx_nx_s   = idx_r + 2'd1;
                    end
                end else begin
                    state_nx_s = ST_READ;
                end
            end
            ST_DONE: begin
                phase_nx_s = 9'd0;
                idx_nx_s   = 2'd0;
                if (CONTINUOUS != 0) begin
                    state_nx_s = ST_ERASE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                phase_nx_s = 9'd0;
                idx_nx_s   = 2'd0;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered strobes align with it.
    always_comb begin
        erase_s   = (state_nx_s == ST_ERASE);
        expose_s  = (state_nx_s == ST_EXPOSE);
        convert_s = (state_nx_s == ST_CONVERT);
        oe_s      = (state_nx_s == ST_CONVERT);
        busy_s    = (state_nx_s != ST_IDLE);
        done_s    = (state_nx_s == ST_DONE);
        if (state_nx_s == ST_READ) begin
            read_s = 4'b0001 << idx_nx_s;
        end else begin
            read_s = 4'b0000;
        end
        // ADC count only moves during conversion; it holds through turnaround and after.
        if (state_nx_s == ST_CONVERT) begin
            if (USE_GRAY != 0) begin
                dout_s = bin2gray(phase_nx_s[7:0]);
            end else begin
                dout_s = phase_nx_s[7:0];
            end
        end else begin
            dout_s = dout_r;
        end
        // Capture on the last READ cycle of each pixel; presented the cycle after.
        cap_s = (state_r == ST_READ) && (phase_r == READ_LAST);
        if (USE_GRAY != 0) begin
            code_s = gray2bin(bus.data_in);
        end else begin
            code_s = bus.data_in;
        end
        valid_s = cap_s;
        if (cap_s) begin
            pix_s     = code_s;
            pix_idx_s = idx_r;
        end else begin
            pix_s     = pix_r;
            pix_idx_s = pix_idx_r;
        end
    end

    // Output registers; reset clears every output, including the held pixel code.
    always_ff @(posedge clk) begin
        if (reset) begin
            erase_r   <= 1'b0;
            expose_r  <= 1'b0;
            convert_r <= 1'b0;
            read_r    <= 4'b0000;
            oe_r      <= 1'b0;
            dout_r    <= 8'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            valid_r   <= 1'b0;
            pix_r     <= 8'd0;
            pix_idx_r <= 2'd0;
        end else begin
            erase_r   <= erase_s;
            expose_r  <= expose_s;
            convert_r <= convert_s;
            read_r    <= read_s;
            oe_r      <= oe_s;
            dout_r    <= dout_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            valid_r   <= valid_s;
            pix_r     <= pix_s;
            pix_idx_r <= pix_idx_s;
        end
    end

    assign bus.ERASE      = erase_r;
    assign bus.EXPOSE     = expose_r;
    assign bus.CONVERT    = convert_r;
    assign bus.READ       = read_r;
    assign bus.data_oe    = oe_r;
    assign bus.data_out   = dout_r;
    assign bus.busy       = busy_r;
    assign bus.frame_done = done_r;
    assign bus.pix_valid  = valid_r;
    assign bus.pix_data   = pix_r;
    assign bus.pix_index  = pix_idx_r;

endmodule
